// File: rtl/pc_pkg.sv
`default_nettype none
// pc_pkg: shared state encoding and default vectors for the fetch PC generator.
// DATA_WIDTH falls back to 32 when no project-wide value has been defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pc_pkg;

  localparam int          DEFAULT_PC_WIDTH     = `DATA_WIDTH;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_INST_BYTES   = 4;

  typedef enum logic [1:0] {
    PC_BOOT    = 2'd0,
    PC_RUN     = 2'd1,
    PC_PENDING = 2'd2
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_buffer.sv
`default_nettype none
// pc_redirect_buffer: holds a redirect target captured during a stall until released.
// Alignment handling is selected by PC_ALIGN_CHECK_EN (check) or its absence (force-align).
module pc_redirect_buffer
  import pc_pkg::*;
#(
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int INST_BYTES = DEFAULT_INST_BYTES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture,
  input  logic                clear,
  input  logic                consume,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                pending_valid,
  output logic [PC_WIDTH-1:0] pending_target,
  output logic [PC_WIDTH-1:0] direct_target,
  output logic                direct_misaligned,
  output logic                pending_misaligned
);

  localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'(INST_BYTES - 1);

  logic [PC_WIDTH-1:0] target_q;
  logic                valid_q;

  // A fresh capture always wins so a newer stalled redirect replaces an older one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (capture) begin
      valid_q  <= 1'b1;
      target_q <= redirect_target;
    end else if (clear || consume) begin
      valid_q  <= 1'b0;
    end
  end

  assign pending_valid = valid_q;

`ifdef PC_ALIGN_CHECK_EN
  assign direct_target      = redirect_target;
  assign pending_target     = target_q;
  assign direct_misaligned  = |(redirect_target & LOW_MASK);
  assign pending_misaligned = |(target_q & LOW_MASK);
`else
  assign direct_target      = redirect_target & ~LOW_MASK;
  assign pending_target     = target_q & ~LOW_MASK;
  assign direct_misaligned  = 1'b0;
  assign pending_misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/pc_gen_unit.sv
`default_nettype none
// pc_gen_unit: fetch-stage PC generator with trap, redirect, buffered-redirect and sequential sources.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirects trap instead of being force-aligned).
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
  parameter int                  INST_BYTES   = DEFAULT_INST_BYTES,
  parameter int                  NUM_STALL    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_STALL-1:0] StallIn,
  input  logic                 FetchReady,
  input  logic                 RedirectValid,
  input  logic [PC_WIDTH-1:0]  RedirectTarget,
  input  logic                 TrapValid,
  output logic [PC_WIDTH-1:0]  PcOutput,
  output logic                 PcValid,
  output logic                 RedirectPending,
  output logic                 MisalignFault
);

  pc_state_e           state, next_state;
  logic [PC_WIDTH-1:0] pc_q, next_pc;
  logic                fault_q, next_fault;
  logic                stall;
  logic                buf_capture, buf_clear, buf_consume;
  logic                pending_valid;
  logic [PC_WIDTH-1:0] pending_target, direct_target;
  logic                direct_misaligned, pending_misaligned;

  assign stall = |StallIn;

  pc_redirect_buffer #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_BYTES (INST_BYTES)
  ) u_redirect_buffer (
    .clk                (clk),
    .reset              (reset),
    .capture            (buf_capture),
    .clear              (buf_clear),
    .consume            (buf_consume),
    .redirect_target    (RedirectTarget),
    .pending_valid      (pending_valid),
    .pending_target     (pending_target),
    .direct_target      (direct_target),
    .direct_misaligned  (direct_misaligned),
    .pending_misaligned (pending_misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PC_BOOT;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
    end else begin
      state   <= next_state;
      pc_q    <= next_pc;
      fault_q <= next_fault;
    end
  end

  always_comb begin
    next_state  = state;
    next_pc     = pc_q;
    next_fault  = 1'b0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    buf_consume = 1'b0;
    if (state == PC_BOOT) begin
      next_state = PC_RUN;
    end else if (TrapValid) begin
      next_pc    = TRAP_VECTOR;
      buf_clear  = 1'b1;
      next_state = PC_RUN;
    end else if (stall && RedirectValid) begin
      buf_capture = 1'b1;
      next_state  = PC_PENDING;
    end else if (stall) begin
      next_state = state;
    end else if (RedirectValid) begin
      // A misaligned target becomes a trap; only possible with the alignment check built in.
      buf_clear  = 1'b1;
      next_state = PC_RUN;
      if (direct_misaligned) begin
        next_pc    = TRAP_VECTOR;
        next_fault = 1'b1;
      end else begin
        next_pc = direct_target;
      end
    end else if (state == PC_PENDING && pending_valid) begin
      buf_consume = 1'b1;
      next_state  = PC_RUN;
      if (pending_misaligned) begin
        next_pc    = TRAP_VECTOR;
        next_fault = 1'b1;
      end else begin
        next_pc = pending_target;
      end
    end else if (FetchReady) begin
      next_pc = pc_q + PC_WIDTH'(INST_BYTES);
    end
  end

  assign PcOutput        = pc_q;
  assign PcValid         = (state != PC_BOOT);
  assign RedirectPending = (state == PC_PENDING);
  assign MisalignFault   = fault_q;

endmodule

`default_nettype wire

// File: doc/pc_gen_unit.md
# pc_gen_unit

Parametrised program-counter generator for the fetch stage, succeeding the single-register PC with three hard-wired stall inputs. Holds the architectural fetch PC and produces the next PC each cycle. Sources, in priority order: trap vector, branch/jump redirect, redirect buffered during a stall, sequential increment. Exposes a valid/ready handshake to instruction fetch and an arbitrary number of stall sources (instruction cache, data cache, hazard unit, ...).

## Interface
- PC_WIDTH, `DATA_WIDTH` width (32): PC width in bits
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap
- INST_BYTES, 4: sequential increment; power of two
- NUM_STALL, 3: number of independent stall sources
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- StallIn  in  NUM_STALL  any bit high freezes sequential/redirect update
- FetchReady  in  1  fetch accepted current PcOutput this cycle
- RedirectValid  in  1  branch/jump resolved taken
- RedirectTarget  in  PC_WIDTH  redirect destination
- TrapValid  in  1  exception/flush request
- PcOutput  out  PC_WIDTH  current fetch PC (registered)
- PcValid  out  1  PcOutput is a valid fetch request
- RedirectPending  out  1  a redirect is buffered awaiting stall release
- MisalignFault  out  1  one-cycle pulse, misaligned redirect (see Configuration)

## Operation
- States: PC_BOOT, PC_RUN, PC_PENDING.
- Reset (async, reset=0): PcOutput=RESET_VECTOR, PcValid=0, RedirectPending=0, MisalignFault=0, pending buffer cleared, state PC_BOOT.
- PC_BOOT: PcOutput held; next edge -> PC_RUN, PcValid=1. PcValid stays 1 thereafter until reset.
- stall = |StallIn. The next-PC decision is made per rising edge, highest priority first:
  - TrapValid: PcOutput<=TRAP_VECTOR, pending cleared, -> PC_RUN. Applies even while stalled.
  - stall & RedirectValid: target captured into the pending buffer, -> PC_PENDING, PcOutput held. A newer redirect overwrites an older pending one.
  - stall only: PcOutput held.
  - !stall & RedirectValid: PcOutput<=RedirectTarget, pending discarded, -> PC_RUN.
  - !stall & PC_PENDING: PcOutput<=pending target, -> PC_RUN.
  - !stall & FetchReady & PcValid: PcOutput<=PcOutput+INST_BYTES.
  - Otherwise: hold.
- Arithmetic is modulo 2^PC_WIDTH. Example: 32'hFFFF_FFFC+4 -> 32'h0000_0000, with no flag.
- RedirectPending = (state==PC_PENDING).

## Timing
- All outputs registered. There is no combinational path from any input to any output.
- Redirect, trap or increment becomes visible on PcOutput one cycle after the qualifying edge.
- A buffered redirect appears on PcOutput one cycle after the first edge with stall=0.
- A redirect and a trap on the same edge: the trap wins and the redirect is dropped.
- Reset asserted mid-stall or mid-pending: the pending buffer is lost and the unit restarts at PC_BOOT.
- FetchReady is ignored while PcValid=0 or stall=1.

## Configuration
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect (direct or buffered) whose low log2(INST_BYTES) bits are nonzero is not taken.
  - Instead, PcOutput<=TRAP_VECTOR, pending is cleared, and MisalignFault pulses high for one cycle, coincident with the update.
  - An explicit TrapValid on the same edge suppresses the pulse.
- Undefined: redirect targets are force-aligned (low bits cleared) and MisalignFault is tied 0.

## Structure
- Shared package pc_pkg holds:
  - typedef enum pc_state_e {PC_BOOT, PC_RUN, PC_PENDING}
  - default RESET_VECTOR/TRAP_VECTOR localparams
  - INST_BYTES default
- PC_WIDTH default comes from `DATA_WIDTH` in Constants.vh.
- One sub-module: pc_redirect_buffer.
  - Contents: pending target register plus valid bit.
  - Controls: capture, clear and consume.
  - Includes the alignment check when PC_ALIGN_CHECK_EN is defined.

## Test plan
- Reset release, FetchReady=1, no stalls -> PcValid rises one cycle after release; PcOutput then steps 0x0, 0x4, 0x8, ...
- PcOutput=0x10, StallIn=3'b010 for 3 cycles with FetchReady=1 -> PcOutput holds 0x10; resumes 0x14 one cycle after stall drops.
- Stall active; RedirectValid with target 0x200, then 0x300 on the next cycle -> RedirectPending=1; PcOutput held. After stall drops, PcOutput=0x300 and RedirectPending=0.
- TrapValid with RedirectValid (0x400), stall active -> PcOutput=0x100 next cycle; pending cleared.
- PcOutput=0xFFFF_FFFC, FetchReady=1 -> PcOutput=0x0000_0000.
- RedirectTarget=0x202:
  - With PC_ALIGN_CHECK_EN: PcOutput=0x100 and MisalignFault pulses once.
  - Without: PcOutput=0x200 and MisalignFault stays 0.
